// File: rtl/dice_ctrl_341446083683025490_if.sv
`default_nettype none
// ============================================================================
// Module      : dice_ctrl_341446083683025490_if
// Description : Signal bundle between the dice roll controller and its
//               surroundings (roll button, LFSR stage, LED/face outputs).
//               master : drives i_roll / i_lfsr, observes the outputs
//               slave  : the controller itself
// Ports       : i_roll    roll button level (asynchronous)
//               i_lfsr    current 3-bit LFSR state
//               o_lfsr_en LFSR step enable
//               o_led     [6:0] pips, [7] busy
//               o_value   settled face 1..6 (0 before first roll)
//               o_valid   face is settled and shown
//               o_stuck   settle gave up and forced face 1
// Revision    : 1.0 - initial release
// ============================================================================
interface dice_ctrl_341446083683025490_if;
    logic       i_roll;
    logic [2:0] i_lfsr;
    logic       o_lfsr_en;
    logic [7:0] o_led;
    logic [2:0] o_value;
    logic       o_valid;
    logic       o_stuck;

    modport master (
        output i_roll,
        output i_lfsr,
        input  o_lfsr_en,
        input  o_led,
        input  o_value,
        input  o_valid,
        input  o_stuck
    );

    modport slave (
        input  i_roll,
        input  i_lfsr,
        output o_lfsr_en,
        output o_led,
        output o_value,
        output o_valid,
        output o_stuck
    );
endinterface
`default_nettype wire

// File: rtl/dice_ctrl_341446083683025490.sv
`default_nettype none
// ============================================================================
// Module      : dice_ctrl_341446083683025490
// Description : Dice roll controller and pip decoder. Synchronises and
//               edge-detects the roll button, steps the LFSR through a
//               visible tumble animation, then settles on a legal face
//               (1..6) and drives the 7-pip LED pattern plus busy flag.
// Ports       : i_clk  clock
//               i_rst  asynchronous active-high reset
//               bus    dice_ctrl_341446083683025490_if.slave (roll, LFSR,
//                      LED, face value, valid, stuck)
// Revision    : 1.0 - initial release
// ============================================================================
module dice_ctrl_341446083683025490 #(
    parameter int TUMBLE_STEPS = 16,
    parameter int STEP_DIV     = 4,
    parameter int STUCK_LIMIT  = 8
) (
    input  wire logic                             i_clk,
    input  wire logic                             i_rst,
    dice_ctrl_341446083683025490_if.slave         bus
);

    localparam int SW = (STEP_DIV    > 1) ? $clog2(STEP_DIV)    : 1;
    localparam int TW = $clog2(TUMBLE_STEPS + 1);
    localparam int IW = (STUCK_LIMIT > 1) ? $clog2(STUCK_LIMIT) : 1;

    localparam logic [SW-1:0] c_step_load   = SW'(STEP_DIV - 1);
    localparam logic [TW-1:0] c_tumble_load = TW'(TUMBLE_STEPS);
    localparam logic [IW-1:0] c_inv_last    = IW'(STUCK_LIMIT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        TUMBLE = 2'd1,
        SETTLE = 2'd2,
        SHOW   = 2'd3
    } state_t;

    state_t        r_state, w_state_nx;
    logic          r_s1, r_s2, r_s3;
    logic [SW-1:0] r_step,   w_step_nx;
    logic [TW-1:0] r_tumble, w_tumble_nx;
    logic [IW-1:0] r_inv,    w_inv_nx;
    logic [2:0]    r_face,   w_face_nx;
    logic [2:0]    r_value,  w_value_nx;
    logic          r_valid,  w_valid_nx;
    logic          r_stuck,  w_stuck_nx;
    logic          r_lfsr_en;
    logic          w_lfsr_en_nx;
    logic          w_accept;
    logic          w_legal;
    logic [6:0]    w_pips;

    // Rising edge of the synchronised button (s3 is a plain delay of s2)
    assign w_accept = r_s2 & ~r_s3;
    assign w_legal  = (bus.i_lfsr != 3'd0) && (bus.i_lfsr != 3'd7);

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= IDLE;
            r_s1      <= 1'b0;
            r_s2      <= 1'b0;
            r_s3      <= 1'b0;
            r_step    <= '0;
            r_tumble  <= '0;
            r_inv     <= '0;
            r_face    <= 3'd0;
            r_value   <= 3'd0;
            r_valid   <= 1'b0;
            r_stuck   <= 1'b0;
            r_lfsr_en <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_s1      <= bus.i_roll;
            r_s2      <= r_s1;
            r_s3      <= r_s2;
            r_step    <= w_step_nx;
            r_tumble  <= w_tumble_nx;
            r_inv     <= w_inv_nx;
            r_face    <= w_face_nx;
            r_value   <= w_value_nx;
            r_valid   <= w_valid_nx;
            r_stuck   <= w_stuck_nx;
            r_lfsr_en <= w_lfsr_en_nx;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and datapath logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nx  = r_state;
        w_step_nx   = r_step;
        w_tumble_nx = r_tumble;
        w_inv_nx    = r_inv;
        w_face_nx   = r_face;
        w_value_nx  = r_value;
        w_valid_nx  = r_valid;
        w_stuck_nx  = r_stuck;

        case (r_state)
            IDLE, SHOW: begin
                if (w_accept) begin
                    w_state_nx  = TUMBLE;
                    w_valid_nx  = 1'b0;
                    w_stuck_nx  = 1'b0;
                    w_face_nx   = 3'd0;
                    w_step_nx   = c_step_load;
                    w_tumble_nx = c_tumble_load;
                end
            end

            TUMBLE: begin
                if (r_step == '0) begin
                    w_step_nx   = c_step_load;
                    w_tumble_nx = r_tumble - TW'(1);
                    // Illegal samples leave the displayed face untouched
                    if (w_legal) begin
                        w_face_nx = bus.i_lfsr;
                    end
                    if (r_tumble == TW'(1)) begin
                        w_state_nx = SETTLE;
                        w_inv_nx   = '0;
                    end
                end else begin
                    w_step_nx = r_step - SW'(1);
                end
            end

            SETTLE: begin
                if (w_legal) begin
                    w_value_nx = bus.i_lfsr;
                    w_face_nx  = bus.i_lfsr;
                    w_valid_nx = 1'b1;
                    w_state_nx = SHOW;
                end else if (r_inv == c_inv_last) begin
                    // LFSR appears locked in an illegal state; give up on it
                    w_value_nx = 3'd1;
                    w_face_nx  = 3'd1;
                    w_valid_nx = 1'b1;
                    w_stuck_nx = 1'b1;
                    w_state_nx = SHOW;
                end else begin
                    w_inv_nx = r_inv + IW'(1);
                end
            end

            default: begin
                w_state_nx = IDLE;
            end
        endcase

        // Registered so the enable coincides with the busy state itself
        w_lfsr_en_nx = (w_state_nx == TUMBLE) || (w_state_nx == SETTLE);
    end

    // ------------------------------------------------------------------
    // Pip decoder: bit0 centre, 1 TL, 2 TR, 3 ML, 4 MR, 5 BL, 6 BR
    // ------------------------------------------------------------------
    always_comb begin
        w_pips = 7'h00;
        case (r_face)
            3'd1:    w_pips = 7'h01;
            3'd2:    w_pips = 7'h42;
            3'd3:    w_pips = 7'h43;
            3'd4:    w_pips = 7'h66;
            3'd5:    w_pips = 7'h67;
            3'd6:    w_pips = 7'h7E;
            default: w_pips = 7'h00;
        endcase
    end

    assign bus.o_led     = {(r_state == TUMBLE) || (r_state == SETTLE), w_pips};
    assign bus.o_lfsr_en = r_lfsr_en;
    assign bus.o_value   = r_value;
    assign bus.o_valid   = r_valid;
    assign bus.o_stuck   = r_stuck;

endmodule
`default_nettype wire

// File: doc/dice_ctrl_341446083683025490.md
Name: dice_ctrl_341446083683025490

Overview:
Roll controller and pip decoder sitting directly downstream of the 3-bit LFSR in the dice design. It debounces nothing but synchronises and edge-detects the roll button, and steps the LFSR via o_lfsr_en during a visible "tumble" animation. It then settles on a legal face (1..6) and drives the 7-pip LED pattern plus a busy indicator on o_led.

Parameters:
TUMBLE_STEPS, 16, number of display samples taken during the tumble animation (>=1)
STEP_DIV, 4, clock cycles between tumble samples (>=1)
STUCK_LIMIT, 8, consecutive invalid samples in SETTLE before forcing face 1 (>=1)

Ports:
i_clk  input  1  clock
i_rst  input  1  reset; asynchronous, active-high
i_roll  input  1  roll button, asynchronous level
i_lfsr  input  3  current LFSR state from the LFSR stage
o_lfsr_en  output  1  LFSR step enable; high in TUMBLE and SETTLE only
o_led  output  8  [6:0] pip pattern, [7] busy (TUMBLE or SETTLE)
o_value  output  3  settled face 1..6; 0 before first roll
o_valid  output  1  high in SHOW only
o_stuck  output  1  sticky: SETTLE hit STUCK_LIMIT; cleared on next accepted roll

Behaviour:
- Reset: asynchronous; all outputs 0, state IDLE, counters 0, sync flops 0, held face 0.
- Roll input: 2-flop synchroniser (s1, s2) plus delay flop s3; accepted edge = s2 & ~s3. With i_roll high before edge 0 and held, state changes on edge 2.
- Accepted edge only in IDLE or SHOW -> TUMBLE: o_valid<=0, o_stuck<=0, held face<=0, step counter<=STEP_DIV-1, tumble counter<=TUMBLE_STEPS. Edges in TUMBLE/SETTLE are ignored (not queued).
- TUMBLE: step counter decrements each cycle. At 0: sample i_lfsr, reload to STEP_DIV-1, decrement tumble counter. If sample is in 1..6, held face<=sample; otherwise held face is unchanged. The sample that brings the tumble counter to 0 also moves the state to SETTLE. Duration is exactly TUMBLE_STEPS*STEP_DIV cycles.
- SETTLE: sample i_lfsr every cycle.
  - Value in 1..6: o_value<=sample, held face<=sample, o_valid<=1, state->SHOW.
  - Value 0 or 7: increment the invalid counter. On reaching STUCK_LIMIT: face 1, o_value<=1, o_stuck<=1, o_valid<=1, state->SHOW.
  - The invalid counter is cleared on entry to SETTLE.
- SHOW: o_value and the pips are held. An accepted edge restarts TUMBLE.
- Pip map: bit0 centre, bit1 top-left, bit2 top-right, bit3 mid-left, bit4 mid-right, bit5 bottom-left, bit6 bottom-right.
  - Faces: 1=0x01, 2=0x42, 3=0x43, 4=0x66, 5=0x67, 6=0x7E.
  - Face 0 (none yet) = 0x00.
- o_led[6:0] is decoded combinationally from the held face. o_led[7] = (state==TUMBLE || state==SETTLE).
- o_lfsr_en is a registered output, asserted in the same cycle the state is TUMBLE/SETTLE.
- Reset mid-roll: immediate return to reset values; no partial face is retained.

Test Plan:
- Reset: assert i_rst with no clock edge -> o_led=0x00, o_value=0, o_valid=0, o_lfsr_en=0, o_stuck=0.
- Nominal (TUMBLE_STEPS=4, STEP_DIV=2, LFSR model seeded 3'b001): pulse i_roll high for 3 cycles.
  - State enters TUMBLE on edge 2; o_led[7] and o_lfsr_en are high for 8 cycles of TUMBLE plus the SETTLE cycles.
  - The final face equals the first legal i_lfsr in SETTLE, e.g. 5 -> o_led=0x67, o_value=5, o_valid=1.
- Invalid skip: drive i_lfsr=7 for the first 3 SETTLE cycles, then 3 -> SHOW on the 4th SETTLE cycle with o_led=0x43, o_value=3, o_stuck=0.
- Stuck: hold i_lfsr=0 throughout -> after 8 SETTLE cycles: o_value=1, o_led=0x01, o_stuck=1. The next accepted roll clears o_stuck and o_valid.
- Re-roll: an i_roll edge during TUMBLE -> ignored (TUMBLE length unchanged). An edge in SHOW -> o_valid drops to 0 and o_led[7] rises on the acceptance edge.
- Async reset mid-TUMBLE: raise i_rst between clock edges -> all outputs 0 before the next edge. After release, state is IDLE and no roll occurs without a new i_roll edge.
